// File: rtl/int_addsub_arbiter.sv
// Round-robin arbiter sharing one registered integer add/sub unit between NREQ requesters.
// Results return in issue order through a 2-entry tagged FIFO; issue is credit-limited to FIFO space.
module int_addsub_arbiter #(
    parameter int RISCV_ARCH = 64,
    parameter int NREQ       = 4,
    parameter int MODE_W     = 7
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_flush,
    input  logic [NREQ-1:0]              i_req_valid,
    output logic [NREQ-1:0]              o_req_ready,
    input  logic [NREQ*RISCV_ARCH-1:0]   i_req_a,
    input  logic [NREQ*RISCV_ARCH-1:0]   i_req_b,
    input  logic [NREQ*MODE_W-1:0]       i_req_mode,
    output logic                         o_au_valid,
    output logic [RISCV_ARCH-1:0]        o_au_a,
    output logic [RISCV_ARCH-1:0]        o_au_b,
    output logic [MODE_W-1:0]            o_au_mode,
    input  logic [RISCV_ARCH-1:0]        i_au_res,
    output logic [NREQ-1:0]              o_resp_valid,
    output logic [RISCV_ARCH-1:0]        o_resp_res,
    input  logic [NREQ-1:0]              i_resp_ready
);
    localparam int IDW = $clog2(NREQ);

    typedef struct packed {
        logic [IDW-1:0]        id;
        logic [RISCV_ARCH-1:0] res;
    } fifo_entry_t;

    logic [IDW-1:0] rr_q, rr_d;
    logic           infl_q, infl_d;
    logic [IDW-1:0] infl_id_q, infl_id_d;
    fifo_entry_t    fifo_q [2];
    fifo_entry_t    fifo_d [2];
    logic           rd_q, rd_d, wr_q, wr_d;
    logic [1:0]     cnt_q, cnt_d;

    logic           found, can_issue, hs, pop;
    logic [IDW-1:0] win;
    logic [IDW:0]   s;
    logic [2:0]     occ;
    fifo_entry_t    head;

    // Winner search starting at the round-robin pointer, wrapping NREQ-1 -> 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            s = {1'b0, rr_q} + (IDW+1)'(i);
            if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
            if (!found && i_req_valid[s[IDW-1:0]]) begin
                found = 1'b1;
                win   = s[IDW-1:0];
            end
        end
    end

    always_comb begin
        head         = fifo_q[rd_q];
        pop          = (cnt_q != 2'd0) && i_resp_ready[head.id];
        occ          = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
        can_issue    = (occ < 3'd2) && !i_flush && i_nrst;
        hs           = found && can_issue;

        o_req_ready  = '0;
        o_au_valid   = hs;
        o_au_a       = '0;
        o_au_b       = '0;
        o_au_mode    = '0;
        if (hs) begin
            o_req_ready[win] = 1'b1;
            o_au_a           = i_req_a[win*RISCV_ARCH +: RISCV_ARCH];
            o_au_b           = i_req_b[win*RISCV_ARCH +: RISCV_ARCH];
            o_au_mode        = i_req_mode[win*MODE_W +: MODE_W];
        end

        o_resp_valid = '0;
        o_resp_res   = '0;
        if (cnt_q != 2'd0) begin
            o_resp_valid[head.id] = 1'b1;
            o_resp_res            = head.res;
        end
    end

    always_comb begin
        rr_d      = rr_q;
        infl_d    = hs;
        infl_id_d = win;
        fifo_d    = fifo_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        if (hs) rr_d = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
        if (i_flush) begin
            infl_d = 1'b0;
            rd_d   = 1'b0;
            wr_d   = 1'b0;
            cnt_d  = 2'd0;
        end else begin
            // Unit result is valid exactly one cycle after issue; credit guarantees room.
            if (infl_q) begin
                fifo_d[wr_q] = '{id: infl_id_q, res: i_au_res};
                wr_d         = ~wr_q;
            end
            if (pop) rd_d = ~rd_q;
            cnt_d = cnt_q + 2'(infl_q) - 2'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            rr_q      <= '0;
            infl_q    <= 1'b0;
            infl_id_q <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            rr_q      <= rr_d;
            infl_q    <= infl_d;
            infl_id_q <= infl_id_d;
            fifo_q    <= fifo_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_int_addsub_arbiter.sv
// Directed bench for int_addsub_arbiter with a registered add/sub unit model (mode 0 = add, 1 = sub).
module tb_int_addsub_arbiter;
    localparam int W = 64;
    localparam int N = 4;
    localparam int M = 7;
    localparam logic [M-1:0] ADD = 7'd0;
    localparam logic [M-1:0] SUB = 7'd1;

    logic           clk = 1'b0;
    logic           nrst, flush;
    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N*M-1:0] req_mode;
    logic           au_valid;
    logic [W-1:0]   au_a, au_b, au_res, resp_res;
    logic [M-1:0]   au_mode;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) au_res <= (au_mode == SUB) ? au_a - au_b : au_a + au_b;

    int_addsub_arbiter #(.RISCV_ARCH(W), .NREQ(N), .MODE_W(M)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_flush(flush),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_mode(req_mode),
        .o_au_valid(au_valid), .o_au_a(au_a), .o_au_b(au_b), .o_au_mode(au_mode),
        .i_au_res(au_res),
        .o_resp_valid(resp_valid), .o_resp_res(resp_res), .i_resp_ready(resp_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [M-1:0] m);
        req_a[k*W +: W]    = a;
        req_b[k*W +: W]    = b;
        req_mode[k*M +: M] = m;
    endtask

    task automatic do_reset;
        nrst      = 1'b0;
        req_valid = '0;
        tick;
        nrst      = 1'b1;
    endtask

    logic [63:0] rr_res [N];

    initial begin
        nrst = 1'b0; flush = 1'b0; resp_ready = '0;
        req_a = '0; req_b = '0; req_mode = '0;
        req_valid = 4'b1111;
        set_req(0, 64'd10, 64'd0, ADD);
        set_req(1, 64'd20, 64'd1, ADD);
        set_req(2, 64'd30, 64'd2, SUB);
        set_req(3, 64'd40, 64'd3, ADD);
        rr_res[0] = 64'd10; rr_res[1] = 64'd21; rr_res[2] = 64'd28; rr_res[3] = 64'd43;

        // Reset: requests pending, nothing may be granted.
        tick; settle;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_auv", 64'(au_valid), 64'd0);
        chk("rst_respv", 64'(resp_valid), 64'd0);
        chk("rst_aua", au_a, 64'd0);
        chk("rst_res", resp_res, 64'd0);

        // Single op, 2-cycle latency.
        tick; nrst = 1'b1; req_valid = 4'b0010; set_req(1, 64'd5, 64'd3, ADD); settle;
        chk("s_ready", 64'(req_ready), 64'(4'b0010));
        chk("s_auv", 64'(au_valid), 64'd1);
        chk("s_aua", au_a, 64'd5);
        chk("s_aub", au_b, 64'd3);
        chk("s_mode", 64'(au_mode), 64'(ADD));
        tick; req_valid = '0; settle;
        chk("s_resp_t1", 64'(resp_valid), 64'd0);
        tick; resp_ready = 4'b1111; settle;
        chk("s_resp_t2", 64'(resp_valid), 64'(4'b0010));
        chk("s_res", resp_res, 64'd8);
        tick; resp_ready = '0; settle;
        chk("s_empty", 64'(resp_valid), 64'd0);
        chk("s_empty_res", resp_res, 64'd0);

        // Round-robin with all requesting and no backpressure.
        set_req(1, 64'd20, 64'd1, ADD);
        do_reset;
        resp_ready = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick;
            req_valid = (c < 6) ? 4'b1111 : 4'b0000;
            settle;
            chk("rr_ready", 64'(req_ready), (c < 6) ? 64'(1 << (c % 4)) : 64'd0);
            if (c >= 2) begin
                chk("rr_respv", 64'(resp_valid), 64'(1 << ((c - 2) % 4)));
                chk("rr_res", resp_res, rr_res[(c - 2) % 4]);
            end
        end

        // Backpressure: two ops fill the credit, issue resumes with the first pop.
        tick; req_valid = 4'b0001; resp_ready = '0; set_req(0, 64'd100, 64'd1, ADD); settle;
        chk("bp_ready0", 64'(req_ready), 64'(4'b0001));
        tick; set_req(0, 64'd101, 64'd1, ADD); settle;
        chk("bp_ready1", 64'(req_ready), 64'(4'b0001));
        tick; settle;
        chk("bp_ready2", 64'(req_ready), 64'd0);
        chk("bp_respv2", 64'(resp_valid), 64'(4'b0001));
        chk("bp_res2", resp_res, 64'd101);
        tick; settle;
        chk("bp_ready3", 64'(req_ready), 64'd0);
        chk("bp_res3", resp_res, 64'd101);
        tick; resp_ready = 4'b0001; set_req(0, 64'd200, 64'd1, ADD); settle;
        chk("bp_resume", 64'(req_ready), 64'(4'b0001));
        chk("bp_res4", resp_res, 64'd101);
        tick; req_valid = '0; settle;
        chk("bp_respv5", 64'(resp_valid), 64'(4'b0001));
        chk("bp_res5", resp_res, 64'd102);
        tick; settle;
        chk("bp_res6", resp_res, 64'd201);
        tick; resp_ready = '0; settle;
        chk("bp_empty", 64'(resp_valid), 64'd0);

        // Head blocking: head owned by 2, only requester 3 ready.
        tick; req_valid = 4'b0100; set_req(2, 64'd30, 64'd2, SUB); settle;
        chk("hb_ready2", 64'(req_ready), 64'(4'b0100));
        tick; req_valid = 4'b1000; set_req(3, 64'd40, 64'd3, ADD); settle;
        chk("hb_ready3", 64'(req_ready), 64'(4'b1000));
        for (int c = 0; c < 3; c++) begin
            tick; resp_ready = 4'b1000; settle;
            chk("hb_ready_blk", 64'(req_ready), 64'd0);
            chk("hb_respv", 64'(resp_valid), 64'(4'b0100));
            chk("hb_res", resp_res, 64'd28);
        end
        tick; req_valid = '0; resp_ready = 4'b1111; settle;
        chk("hb_pop2", 64'(resp_valid), 64'(4'b0100));
        tick; settle;
        chk("hb_pop3", 64'(resp_valid), 64'(4'b1000));
        chk("hb_res3", resp_res, 64'd43);
        tick; settle;
        chk("hb_empty", 64'(resp_valid), 64'd0);

        // Flush one cycle after issue drops the result and blocks grant that cycle.
        tick; req_valid = 4'b0001; set_req(0, 64'd1, 64'd1, ADD); settle;
        chk("fl_ready", 64'(req_ready), 64'(4'b0001));
        tick; flush = 1'b1; settle;
        chk("fl_noready", 64'(req_ready), 64'd0);
        chk("fl_noauv", 64'(au_valid), 64'd0);
        tick; flush = 1'b0; set_req(0, 64'd2, 64'd2, ADD); settle;
        chk("fl_dropped", 64'(resp_valid), 64'd0);
        chk("fl_regrant", 64'(req_ready), 64'(4'b0001));
        tick; req_valid = '0; settle;
        chk("fl_t3", 64'(resp_valid), 64'd0);
        tick; settle;
        chk("fl_respv", 64'(resp_valid), 64'(4'b0001));
        chk("fl_res", resp_res, 64'd4);
        tick; settle;
        chk("fl_empty", 64'(resp_valid), 64'd0);

        // Synchronous reset with two buffered results.
        tick; req_valid = 4'b0001; resp_ready = '0; set_req(0, 64'd7, 64'd1, ADD); settle;
        chk("mr_ready0", 64'(req_ready), 64'(4'b0001));
        tick; set_req(0, 64'd9, 64'd1, ADD); settle;
        chk("mr_ready1", 64'(req_ready), 64'(4'b0001));
        tick; req_valid = '0; settle;
        chk("mr_res", resp_res, 64'd8);
        tick; nrst = 1'b0; req_valid = 4'b1111; settle;
        chk("mr_full", 64'(resp_valid), 64'(4'b0001));
        chk("mr_rst_ready", 64'(req_ready), 64'd0);
        tick; nrst = 1'b1; settle;
        chk("mr_cleared", 64'(resp_valid), 64'd0);
        chk("mr_cleared_res", resp_res, 64'd0);
        chk("mr_grant0", 64'(req_ready), 64'(4'b0001));
        tick; req_valid = '0; resp_ready = 4'b1111; settle;
        chk("mr_t1", 64'(resp_valid), 64'd0);
        tick; settle;
        chk("mr_respv", 64'(resp_valid), 64'(4'b0001));
        chk("mr_newres", resp_res, 64'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/int_addsub_arbiter.md
Name: int_addsub_arbiter

Overview:
- Shares one integer add/sub unit between NREQ requesters, e.g. ALU issue, address generation, branch compare and the multi-cycle sequencers.
- Grants one operation per cycle using round-robin arbitration and drives the unit's operand/mode inputs.
- Captures the unit's registered result one cycle later and returns it to the issuing requester through a 2-entry tagged result FIFO.
- Sits in riverlib/core/arith next to the add/sub unit.

Parameters:
- RISCV_ARCH, 64: operand/result width.
- NREQ, 4: number of requesters, 2..8.
- MODE_W, 7: width of the opaque operation-select field, passed through unchanged to the unit.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_nrst  in  1  reset, synchronous, active-low.
- i_flush  in  1  drop all in-flight and buffered results.
- i_req_valid  in  NREQ  request valid, one bit per requester.
- o_req_ready  out  NREQ  grant/accept, at most one bit set.
- i_req_a  in  NREQ*RISCV_ARCH  operand A, requester k at slice [k*RISCV_ARCH +: RISCV_ARCH].
- i_req_b  in  NREQ*RISCV_ARCH  operand B, same slicing.
- i_req_mode  in  NREQ*MODE_W  operation select per requester.
- o_au_valid  out  1  unit strobe, equals a request handshake this cycle.
- o_au_a  out  RISCV_ARCH  operand A to unit.
- o_au_b  out  RISCV_ARCH  operand B to unit.
- o_au_mode  out  MODE_W  operation select to unit.
- i_au_res  in  RISCV_ARCH  unit result, valid exactly 1 cycle after o_au_valid.
- o_resp_valid  out  NREQ  result valid, one-hot to the owner of the FIFO head.
- o_resp_res  out  RISCV_ARCH  result of the FIFO head.
- i_resp_ready  in  NREQ  per-requester result accept.

Behaviour:
- Reset (i_nrst=0 at a clock edge):
  - RR pointer=0, inflight=0, FIFO empty (count=0, rd/wr ptr=0).
  - Outputs: o_req_ready=0, o_au_valid=0, o_resp_valid=0.
  - o_au_a/b/mode=0 when no grant; o_resp_res=0 when FIFO empty.
- Credit:
  - pop = o_resp_valid[head_id] & i_resp_ready[head_id].
  - can_issue = (count + inflight - pop) < 2, and i_flush=0, and i_nrst=1.
- Arbitration (combinational in cycle T):
  - Winner = first k with i_req_valid[k]=1, searching from RR pointer upward with wrap NREQ-1 -> 0.
  - o_req_ready[winner]=can_issue; all other ready bits are 0.
  - A requester with valid=0 never gets ready. Ready does not depend on the requester's own valid beyond winner selection.
- Handshake T (valid & ready):
  - o_au_valid=1 and o_au_a/b/mode = winner's fields in the same cycle.
  - Registered: inflight<=1, inflight_id<=winner, RR pointer <= (winner+1) mod NREQ.
  - With no handshake: inflight<=0, pointer unchanged.
- Cycle T+1: if inflight=1, push {inflight_id, i_au_res} into FIFO. The push cannot overflow, guaranteed by credit.
- Cycle T+2: entry at FIFO head drives o_resp_valid[id]=1 and o_resp_res. Issue-to-response latency is exactly 2 cycles when the FIFO is empty.
- Head held stable until popped. Only the head owner's ready counts; the other i_resp_ready bits are ignored.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Throughput: 1 op/cycle sustained when consumers are always ready. Any stalled head throttles every requester; this is accepted by design.
- Fairness: with all NREQ requesting and no backpressure, each k is granted once in every NREQ consecutive grants.
- i_flush=1:
  - Next cycle FIFO empty and inflight=0.
  - The T+1 push is suppressed if flush is asserted in T+1.
  - No grant that cycle; RR pointer kept.
- Reset mid-operation: same as flush, plus RR pointer=0; an in-flight result is discarded.
- Width rules: result is passed through unmodified at RISCV_ARCH bits. FIFO tag width is clog2(NREQ).

Test Plan:
- Single op, 2 cycles: reset, then req1 valid, a=5, b=3, mode=ADD (unit model returns a+b) -> ready[1]=1 same cycle; o_resp_valid=0010 with res=8 exactly 2 cycles later.
- Round-robin: all 4 valid continuously, resp_ready=1111 -> grants 0,1,2,3,0,1 on consecutive cycles; responses arrive in the same order with matching tags.
- Backpressure: req0 streams with i_resp_ready=0 -> exactly 2 ops accepted, then ready=0. Raising resp_ready gives one pop per cycle and issue resumes the same cycle as the first pop.
- Head blocking: head owned by 2, requester 3 active; i_resp_ready=1000 -> head holds, o_resp_valid=0100 stable, no pop.
- Flush: issue at T, assert i_flush at T+1 -> no o_resp_valid ever for that op; FIFO empty and a new grant is possible at T+2.
- Sync reset mid-op: i_nrst=0 for one edge while FIFO holds 2 entries -> all o_resp_valid=0 next cycle; next grant goes to req0 when all valid.
